lsu_load_unit: RTL

//  Load-return half of the LSU: turns an EX/MEM load request into DMEM/I-O read addresses and delivers

---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/load_align.sv | 26 ++
 rtl/lsu_load_unit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the LSU load path.
// Region map, funct3 encodings and small combinational classifiers.
package lsu_pkg;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } funct3_e;

   typedef enum logic [1:0] {
      REG_DMEM = 2'd0,
      REG_IO   = 2'd1,
      REG_NONE = 2'd2
   } region_e;

   localparam logic [15:0] DMEM_BASE = 16'h0000;
   localparam logic [15:0] IO_BASE0  = 16'h1000;
   localparam logic [15:0] IO_BASE1  = 16'h1001;

   function automatic region_e decode_region(input logic [15:0] hi);
      if (hi == DMEM_BASE) return REG_DMEM;
      if (hi == IO_BASE0 || hi == IO_BASE1) return REG_IO;
      return REG_NONE;
   endfunction

   function automatic logic f3_invalid(input logic [2:0] f3);
      return !(f3 == LB || f3 == LH || f3 == LW || f3 == LBU || f3 == LHU);
   endfunction

   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
      return ((f3 == LH || f3 == LHU) && off[0]) || (f3 == LW && off != 2'b00);
   endfunction

   // Access spills into the next word: only these need the two-read sequence.
   function automatic logic crosses_word(input logic [2:0] f3, input logic [1:0] off);
      return ((f3 == LH || f3 == LHU) && off == 2'b11) || (f3 == LW && off != 2'b00);
   endfunction

endpackage

// File: rtl/load_align.sv
// Shifts a little-endian word pair right by a byte offset and extends the
// selected byte/half/word according to funct3.
module load_align
   import lsu_pkg::*;
(
   input  logic [63:0] pair,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [31:0] shifted;

   always_comb begin
      shifted = 32'(pair >> {offset, 3'b000});
      case (funct3)
         LB:      result = {{24{shifted[7]}}, shifted[7:0]};
         LH:      result = {{16{shifted[15]}}, shifted[15:0]};
         LW:      result = shifted;
         LBU:     result = {24'h0, shifted[7:0]};
         LHU:     result = {16'h0, shifted[15:0]};
         default: result = 32'h0;
      endcase
   end

endmodule

// File: rtl/lsu_load_unit.sv
// Load-return half of the LSU: issues DMEM read addresses and returns extended load data.
// Define LSU_MISALIGNED_SPLIT_EN to service word-crossing DMEM loads with a second read.
module lsu_load_unit
   import lsu_pkg::*;
#(
   parameter int unsigned DMEM_AW = 16
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_req_valid,
   input  logic               i_req_kill,
   input  logic [31:0]        i_req_addr,
   input  logic [2:0]         i_req_funct3,
   output logic [DMEM_AW-1:0] o_dmem_addr,
   input  logic [31:0]        i_dmem_rdata,
   input  logic [31:0]        i_io_rdata,
   output logic               o_stall,
   output logic               o_ld_valid,
   output logic [31:0]        o_ld_data,
   output logic               o_ld_fault
);

   typedef enum logic {StIdle, StSecond} state_e;

   state_e             state;
   logic               pend;
   logic               pend_fault;
   region_e            pend_region;
   logic [1:0]         pend_off;
   logic [2:0]         pend_f3;
   logic               split_pend;
   logic [DMEM_AW-1:0] split_addr;
   logic [31:0]        split_first;
   logic [31:0]        ld_hold;

   region_e            req_region;
   logic               req_inv;
   logic               req_mis;
   logic               req_fault;
   logic               split_needed;
   logic [DMEM_AW-1:0] word_addr;
   logic [31:0]        region_word;
   logic [63:0]        pair;
   logic [31:0]        aligned;

   assign req_region = decode_region(i_req_addr[31:16]);
   assign req_inv    = f3_invalid(i_req_funct3);
   assign req_mis    = is_misaligned(i_req_funct3, i_req_addr[1:0]);
   assign word_addr  = {i_req_addr[DMEM_AW-1:2], 2'b00};

`ifdef LSU_MISALIGNED_SPLIT_EN
   logic req_cross;
   assign req_cross    = crosses_word(i_req_funct3, i_req_addr[1:0]);
   // I/O is never split, so misaligned I/O still faults.
   assign req_fault    = req_inv | (req_mis & (req_region == REG_IO));
   assign split_needed = (state == StIdle) & i_req_valid & ~i_req_kill &
                         (req_region == REG_DMEM) & ~req_inv & req_cross;
   assign o_stall      = split_needed;
`else
   assign req_fault    = req_inv | req_mis;
   assign split_needed = 1'b0;
   assign o_stall      = 1'b0;
`endif

   always_comb begin
      if (i_reset)                o_dmem_addr = '0;
      else if (state == StSecond) o_dmem_addr = split_addr;
      else                        o_dmem_addr = word_addr;
   end

   always_comb begin
      case (pend_region)
         REG_DMEM: region_word = i_dmem_rdata;
         REG_IO:   region_word = i_io_rdata;
         default:  region_word = 32'h0;
      endcase
   end

   // Second word arrives on i_dmem_rdata in the merge cycle; the first was captured in SECOND.
   assign pair = split_pend ? {i_dmem_rdata, split_first} : {32'h0, region_word};

   load_align u_align (
      .pair   (pair),
      .offset (pend_off),
      .funct3 (pend_f3),
      .result (aligned)
   );

   assign o_ld_valid = pend | split_pend;
   assign o_ld_fault = pend & pend_fault;

   always_comb begin
      if (o_ld_fault)      o_ld_data = 32'h0;
      else if (o_ld_valid) o_ld_data = aligned;
      else                 o_ld_data = ld_hold;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state       <= StIdle;
         pend        <= 1'b0;
         pend_fault  <= 1'b0;
         pend_region <= REG_DMEM;
         pend_off    <= 2'b00;
         pend_f3     <= 3'b000;
         split_pend  <= 1'b0;
         split_addr  <= '0;
         split_first <= 32'h0;
         ld_hold     <= 32'h0;
      end else begin
         pend       <= 1'b0;
         pend_fault <= 1'b0;
         split_pend <= 1'b0;
         if (o_ld_valid) ld_hold <= o_ld_data;
         case (state)
            StIdle: begin
               if (i_req_valid && !i_req_kill) begin
                  pend_off    <= i_req_addr[1:0];
                  pend_f3     <= i_req_funct3;
                  pend_region <= req_region;
                  if (split_needed) begin
                     state      <= StSecond;
                     split_addr <= word_addr + DMEM_AW'(4);
                  end else begin
                     pend       <= 1'b1;
                     pend_fault <= req_fault;
                  end
               end
            end
            StSecond: begin
               // The held request on the inputs is not re-decoded here.
               state <= StIdle;
               if (!i_req_kill) begin
                  split_first <= i_dmem_rdata;
                  split_pend  <= 1'b1;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule
